// File: rtl/softmc_arb_pkg.sv
// Shared types and constants for the SoftMC instruction arbiter.
// The optional perf counters are enabled with SOFTMC_ARB_PERF_EN.
package softmc_arb_pkg;

    localparam int unsigned ARB_INSTR_W = 32;
    localparam int unsigned PERF_W      = 32;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Next round-robin start position; modulo n, so non-power-of-two counts wrap correctly
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/softmc_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
// Built as rotate / find-first / unrotate so it can be reused for other channels.
module softmc_rr_picker #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    localparam int unsigned SUM_W = ID_W + 1;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      ff;
    logic [SUM_W-1:0]     sum;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NUM_REQ];
    assign found   = |req;

    // Lowest set bit of the rotated vector is the nearest request after ptr
    always_comb begin
        ff = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                ff = ID_W'(i);
            end
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, ff};
    assign idx = (sum >= SUM_W'(NUM_REQ)) ? ID_W'(sum - SUM_W'(NUM_REQ)) : ID_W'(sum);

endmodule

// File: rtl/softmc_instr_arbiter.sv
// Burst-atomic round-robin arbiter in front of the MC instruction port, registered output stage.
// Define SOFTMC_ARB_PERF_EN to build per-requester accepted-beat counters on perf_beats.
module softmc_instr_arbiter
    import softmc_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    parameter int unsigned  INSTR_W = ARB_INSTR_W,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*INSTR_W-1:0]  req_instr,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        app_en,
    output logic [INSTR_W-1:0]          app_instr,
    input  logic                        app_ack,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy,
    input  logic                        perf_clr,
    output logic [NUM_REQ*PERF_W-1:0]   perf_beats
);

    arb_state_t         state;
    logic [ID_W-1:0]    rr_ptr;
    logic               load;
    logic               locked;
    logic               beat_taken;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [INSTR_W-1:0] instr_arr [NUM_REQ];

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_split
        assign instr_arr[i] = req_instr[i*INSTR_W +: INSTR_W];
    end

    softmc_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Output register can take a new beat when empty or being consumed this cycle
    assign load       = !app_en || app_ack;
    assign locked     = (state == ARB_LOCKED);
    assign req_ready  = (locked && load) ? (NUM_REQ'(1) << grant_id) : '0;
    assign beat_taken = locked && load && req_valid[grant_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_en    <= 1'b0;
            app_instr <= '0;
        end else if (load) begin
            app_en    <= beat_taken;
            app_instr <= instr_arr[grant_id];
        end
    end

    // Grant is held for the whole burst; a stalled granted requester is not preempted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        state    <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (beat_taken && req_last[grant_id]) begin
                        state  <= ARB_IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= ID_W'(rr_next(32'(grant_id), NUM_REQ));
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef SOFTMC_ARB_PERF_EN
    // Saturating counters; a clear takes priority over a same-cycle increment
    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_perf
        logic [PERF_W-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (perf_clr) begin
                cnt <= '0;
            end else if (req_valid[i] && req_ready[i] && (cnt != '1)) begin
                cnt <= cnt + PERF_W'(1);
            end
        end

        assign perf_beats[i*PERF_W +: PERF_W] = cnt;
    end
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr;
    assign perf_beats      = '0;
`endif

endmodule

// File: tb/tb_softmc_instr_arbiter.sv
// Self-checking bench for softmc_instr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the round-robin burst arbiter.
`timescale 1ns/1ps
module tb_softmc_instr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int PW = 32;

    typedef struct {
        logic [W-1:0] d;
        bit           last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_instr = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            app_en;
    logic [W-1:0]    app_instr;
    logic            app_ack = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            perf_clr = 1'b0;
    logic [N*PW-1:0] perf_beats;

    softmc_instr_arbiter #(
        .NUM_REQ (N),
        .INSTR_W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_instr  (req_instr),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .app_en     (app_en),
        .app_instr  (app_instr),
        .app_ack    (app_ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .perf_clr   (perf_clr),
        .perf_beats (perf_beats)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: pending bursts per source, MC-side register, grant/pointer, beat counts
    beat_t        src_q [N][$];
    bit           hold [N];
    bit           m_en;
    logic [W-1:0] m_instr;
    bit           m_locked;
    int           m_grant;
    int           m_ptr;
    logic [PW-1:0] m_cnt [N];
    int           m_acc;

    logic [W-1:0] out_log [$];
    int           out_cyc [$];
    int           glog [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_instr = '0; m_locked = 1'b0; m_grant = 0; m_ptr = 0; m_acc = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = '0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            hold[i] = 1'b0;
        end
    endtask

    task automatic clear_logs();
        out_log.delete(); out_cyc.delete(); glog.delete();
    endtask

    task automatic push(input int r, input logic [W-1:0] d, input bit last);
        beat_t b;
        b.d = d; b.last = last;
        src_q[r].push_back(b);
    endtask

    function automatic bit work_left();
        bit w = m_locked || m_en;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) w = 1'b1;
        return w;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                req_valid[i]         = 1'b1;
                req_instr[i*W +: W]  = src_q[i][0].d;
                req_last[i]          = src_q[i][0].last;
            end else begin
                req_valid[i]         = 1'b0;
                req_instr[i*W +: W]  = $urandom;
                req_last[i]          = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic compare();
        bit           load;
        logic [N-1:0] er;
        logic [PW-1:0] ep;
        load = !m_en || app_ack;
        er   = (m_locked && load) ? (N'(1) << m_grant) : '0;
        chk("app_en", 64'(app_en), 64'(m_en));
        if (m_en) chk("app_instr", 64'(app_instr), 64'(m_instr));
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        chk("busy", 64'(busy), 64'(m_locked));
        for (int i = 0; i < N; i++) begin
`ifdef SOFTMC_ARB_PERF_EN
            ep = m_cnt[i];
`else
            ep = '0;
`endif
            chk("perf_beats", 64'(perf_beats[i*PW +: PW]), 64'(ep));
        end
        if (app_en && app_ack) begin
            out_log.push_back(app_instr);
            out_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) glog.push_back(i);
    endtask

    task automatic model_update();
        bit load, taken;
        int j;
        load  = !m_en || app_ack;
        taken = m_locked && load && req_valid[m_grant];
        if (load) begin
            m_en = taken;
            if (taken) m_instr = req_instr[m_grant*W +: W];
        end
        if (perf_clr) begin
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
        end else if (taken && m_cnt[m_grant] != '1) begin
            m_cnt[m_grant] = m_cnt[m_grant] + 1;
        end
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (req_valid[j]) begin
                    m_grant  = j;
                    m_locked = 1'b1;
                    break;
                end
            end
        end else if (taken) begin
            m_acc++;
            void'(src_q[m_grant].pop_front());
            if (req_last[m_grant]) begin
                m_locked = 1'b0;
                m_ptr    = (m_grant + 1) % N;
            end
        end
    endtask

    task automatic finish_cycle();
        compare();
        model_update();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        drive();
        #1;
        finish_cycle();
    endtask

    task automatic run_until_idle(input int max, input string name);
        int n = 0;
        app_ack = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        while (work_left() && n < max) begin
            step();
            n++;
        end
        if (work_left()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; app_ack = 1'b0; perf_clr = 1'b0;
        clear_sources();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_app_en", 64'(app_en), 64'd0);
        chk("rst_app_instr", 64'(app_instr), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_perf", 64'(|perf_beats), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // 1: three-beat burst from req0 streams out on consecutive cycles
        do_reset();
        clear_logs();
        push(0, 32'h11, 1'b0); push(0, 32'h22, 1'b0); push(0, 32'h33, 1'b1);
        run_until_idle(50, "t1");
        chk("t1_count", 64'(out_log.size()), 64'd3);
        chk("t1_b0", 64'(out_log[0]), 64'h11);
        chk("t1_b1", 64'(out_log[1]), 64'h22);
        chk("t1_b2", 64'(out_log[2]), 64'h33);
        chk("t1_consec", 64'(out_cyc[2] - out_cyc[0]), 64'd2);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_model_ptr", 64'(m_ptr), 64'd1);

        // 2: req0 and req2 together from rr_ptr 0, bursts do not interleave
        do_reset();
        clear_logs();
        push(0, 32'hA0, 1'b0); push(0, 32'hA1, 1'b1);
        push(2, 32'hC0, 1'b0); push(2, 32'hC1, 1'b1);
        run_until_idle(50, "t2");
        chk("t2_o0", 64'(out_log[0]), 64'hA0);
        chk("t2_o1", 64'(out_log[1]), 64'hA1);
        chk("t2_o2", 64'(out_log[2]), 64'hC0);
        chk("t2_o3", 64'(out_log[3]), 64'hC1);
        chk("t2_g0", 64'(glog[0]), 64'd0);
        chk("t2_g2", 64'(glog[2]), 64'd2);
        chk("t2_bubble", 64'(out_cyc[2] - out_cyc[1]), 64'd2);

        // 3: MC stalls five cycles with a beat pending
        clear_logs();
        push(1, 32'h31, 1'b0); push(1, 32'h32, 1'b0); push(1, 32'h33, 1'b1);
        app_ack = 1'b1;
        for (int n = 0; n < 10 && !m_en; n++) step();
        app_ack = 1'b0;
        repeat (5) begin
            drive();
            #1;
            chk("t3_en", 64'(app_en), 64'd1);
            chk("t3_stable", 64'(app_instr), 64'h31);
            chk("t3_ready", 64'(req_ready), 64'd0);
            finish_cycle();
        end
        run_until_idle(50, "t3");
        chk("t3_o1", 64'(out_log[1]), 64'h32);
        chk("t3_o2", 64'(out_log[2]), 64'h33);

        // 4: granted req1 pauses mid-burst, req3 must wait
        clear_logs();
        push(1, 32'h41, 1'b0); push(1, 32'h42, 1'b0); push(1, 32'h43, 1'b0); push(1, 32'h44, 1'b1);
        app_ack = 1'b1;
        step();
        step();
        push(3, 32'h71, 1'b0); push(3, 32'h72, 1'b1);
        hold[1] = 1'b1;
        repeat (4) begin
            drive();
            #1;
            chk("t4_grant", 64'(grant_id), 64'd1);
            chk("t4_ready3", 64'(req_ready[3]), 64'd0);
            finish_cycle();
        end
        run_until_idle(50, "t4");
        chk("t4_glen", 64'(glog.size()), 64'd6);
        chk("t4_g3", 64'(glog[3]), 64'd1);
        chk("t4_g4", 64'(glog[4]), 64'd3);
        chk("t4_o4", 64'(out_log[4]), 64'h71);

        // 5: reset while locked with a beat on the MC port
        clear_logs();
        push(2, 32'h51, 1'b0); push(2, 32'h52, 1'b0); push(2, 32'h53, 1'b0); push(2, 32'h54, 1'b1);
        app_ack = 1'b0;
        repeat (3) step();
        drive();
        #1;
        chk("t5_en_pre", 64'(app_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_en_rst", 64'(app_en), 64'd0);
        chk("t5_ready_rst", 64'(req_ready), 64'd0);
        chk("t5_busy_rst", 64'(busy), 64'd0);
        clear_sources();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        push(3, 32'h63, 1'b1);
        push(1, 32'h61, 1'b1);
        app_ack = 1'b1;
        step();
        #1;
        chk("t5_first_grant", 64'(grant_id), 64'd1);
        run_until_idle(50, "t5");
        chk("t5_o0", 64'(out_log[0]), 64'h61);
        chk("t5_o1", 64'(out_log[1]), 64'h63);

        // 6: per-requester beat counters
`ifdef SOFTMC_ARB_PERF_EN
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        for (int b = 0; b < 10; b++) push(2, 32'h200 + b, b == 9);
        run_until_idle(50, "t6a");
        chk("t6_cnt10", 64'(perf_beats[2*PW +: PW]), 64'd10);
        push(2, 32'h300, 1'b0); push(2, 32'h301, 1'b0); push(2, 32'h302, 1'b1);
        app_ack = 1'b1;
        step();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("t6_clr_wins", 64'(perf_beats[2*PW +: PW]), 64'd0);
        run_until_idle(50, "t6b");
        chk("t6_cnt2", 64'(perf_beats[2*PW +: PW]), 64'd2);
`else
        for (int b = 0; b < 10; b++) push(2, 32'h200 + b, b == 9);
        perf_clr = 1'b1;
        run_until_idle(50, "t6");
        perf_clr = 1'b0;
        chk("t6_perf_zero", 64'(|perf_beats), 64'd0);
`endif

        // Randomized traffic: random bursts, valid drops, MC back-pressure, counter clears
        do_reset();
        clear_logs();
        for (int c = 0; c < 3000; c++) begin
            app_ack  = ($urandom_range(0, 9) < 7);
            perf_clr = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                hold[i] = ($urandom_range(0, 99) < 15);
                if (src_q[i].size() == 0 && $urandom_range(0, 9) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 5));
                    for (int b = 0; b < len; b++) push(i, $urandom, b == len - 1);
                end
            end
            step();
        end
        perf_clr = 1'b0;
        run_until_idle(300, "rand");
        chk("rand_beats", 64'(out_log.size()), 64'(m_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
